branch_target_table: RTL and testbench

- Parametrised, runtime-programmable successor to the fixed branch-target lookup table.
- Direct-mapped, tagged table: maps a KEY_W-bit branch key (PC/opcode hash) to a TGT_W-bit jump target.
- Registered 1-cycle lookup with hit/miss indication.
- Loaded by the boot loader or test bench through a write handshake. Sits between the fetch/decode stage and the PC-next mux.

---
 rtl/branch_target_pkg.sv | 18 +
 rtl/btt_clear_ctrl.sv | 37 +++
 rtl/branch_target_table.sv | 110 +++++++++++
 tb/tb_branch_target_table.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/branch_target_pkg.sv
// branch_target_pkg: shared types and constants for the branch target table
package branch_target_pkg;
    localparam int KEY_W_DEF = 9;
    localparam int TGT_W_DEF = 16;
    localparam int DEPTH_DEF = 32;
    localparam int IDX_W_DEF = $clog2(DEPTH_DEF);
    localparam int TAG_W_DEF = KEY_W_DEF - IDX_W_DEF;
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [TGT_W_DEF-1:0] target;
    } entry_t;
    localparam logic [TGT_W_DEF-1:0] RSP_MISS_TARGET = '0;
endpackage

// File: rtl/btt_clear_ctrl.sv
// btt_clear_ctrl: CLEAR/READY sequencer that walks every entry index once after reset or flush
module btt_clear_ctrl
    import branch_target_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_ready,
    output logic             o_clr_en,
    output logic [IDX_W-1:0] o_clr_idx
);
    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;

    // sweep r_ptr through all DEPTH indices, then idle in READY until the next flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else if (i_flush) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else if (r_state == CLEAR) begin
            r_ptr <= r_ptr + IDX_W'(1);
            if (r_ptr == IDX_W'(DEPTH - 1)) r_state <= READY;
        end
    end

    assign o_busy    = (r_state == CLEAR);
    assign o_ready   = (r_state == READY);
    assign o_clr_en  = (r_state == CLEAR);
    assign o_clr_idx = r_ptr;
endmodule

// File: rtl/branch_target_table.sv
// branch_target_table: direct-mapped tagged key->target table with 1-cycle lookup; BRANCH_TARGET_TABLE_STATS_EN adds hit/miss counters
module branch_target_table
    import branch_target_pkg::*;
#(
    parameter int KEY_W = 9,
    parameter int TGT_W = 16,
    parameter int DEPTH = 32
`ifdef BRANCH_TARGET_TABLE_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [TGT_W-1:0] wr_target,
    input  logic             lk_valid,
    input  logic [KEY_W-1:0] lk_key,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [TGT_W-1:0] rsp_target,
    output logic             busy
`ifdef BRANCH_TARGET_TABLE_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = KEY_W - IDX_W;
    // a full-width index leaves no tag; keep one constant-zero bit so compares stay true
    localparam int TW    = (TAG_W > 0) ? TAG_W : 1;

    logic [DEPTH-1:0] r_valid;
    logic [TW-1:0]    r_tag [DEPTH];
    logic [TGT_W-1:0] r_tgt [DEPTH];

    logic             w_ready, w_clr_en, w_wr_acc, w_same_idx, w_hit;
    logic [IDX_W-1:0] w_clr_idx, w_wr_idx, w_lk_idx;
    logic [TW-1:0]    w_wr_tag, w_lk_tag;
    logic [TGT_W-1:0] w_tgt;

    btt_clear_ctrl #(.DEPTH(DEPTH)) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .o_busy    (busy),
        .o_ready   (w_ready),
        .o_clr_en  (w_clr_en),
        .o_clr_idx (w_clr_idx)
    );

    assign wr_ready   = w_ready && !flush;
    assign w_wr_acc   = wr_valid && wr_ready;
    assign w_wr_idx   = wr_key[IDX_W-1:0];
    assign w_lk_idx   = lk_key[IDX_W-1:0];
    assign w_wr_tag   = TW'(wr_key >> IDX_W);
    assign w_lk_tag   = TW'(lk_key >> IDX_W);
    // a write landing on the looked-up slot this cycle decides the answer: it is the new occupant
    assign w_same_idx = w_wr_acc && (w_wr_idx == w_lk_idx);
    assign w_hit      = w_ready && !flush &&
                        (w_same_idx ? (wr_key == lk_key)
                                    : (r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag)));
    assign w_tgt      = w_hit ? (w_same_idx ? wr_target : r_tgt[w_lk_idx])
                              : TGT_W'(RSP_MISS_TARGET);

    // storage: clear sweep invalidates one slot per cycle, accepted writes fill a slot
    always_ff @(posedge clk) begin
        if (w_clr_en) r_valid[w_clr_idx] <= 1'b0;
        if (w_wr_acc) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_tag[w_wr_idx]   <= w_wr_tag;
            r_tgt[w_wr_idx]   <= wr_target;
        end
    end

    // registered response; hit/target hold between lookups
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_target <= '0;
        end else begin
            rsp_valid <= lk_valid;
            if (lk_valid) begin
                rsp_hit    <= w_hit;
                rsp_target <= w_tgt;
            end
        end
    end

`ifdef BRANCH_TARGET_TABLE_STATS_EN
    // saturating response counters, cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (flush) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rsp_valid) begin
            if (rsp_hit && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
            if (!rsp_hit && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_branch_target_table.sv
// tb_branch_target_table: randomized + directed bench against a keyed reference model
module tb_branch_target_table;
    localparam int CW = 2;
    logic        clk = 0, rst_n = 0, flush = 0, wr_valid = 0, lk_valid = 0;
    logic [8:0]  wr_key = 0, lk_key = 0;
    logic [15:0] wr_target = 0;
    logic        wr_ready, rsp_valid, rsp_hit, busy;
    logic [15:0] rsp_target;
`ifdef BRANCH_TARGET_TABLE_STATS_EN
    logic [CW-1:0] hit_count, miss_count;
`endif

    branch_target_table #(
        .KEY_W(9), .TGT_W(16), .DEPTH(32)
`ifdef BRANCH_TARGET_TABLE_STATS_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_key(wr_key), .wr_target(wr_target),
        .lk_valid(lk_valid), .lk_key(lk_key),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_target(rsp_target), .busy(busy)
`ifdef BRANCH_TARGET_TABLE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    // model: each slot remembers the full key it holds; busy is a countdown of clearing cycles
    bit          mval [32];
    logic [8:0]  mkey [32];
    logic [15:0] mtgt [32];
    int          mclr;
    bit          e_rv, e_hit;
    logic [15:0] e_tgt;
    int          mh, mm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mval[i]) mval[i] = 0;
        mclr = 32; e_rv = 0; e_hit = 0; e_tgt = 0; mh = 0; mm = 0;
    endtask

    task automatic cyc();
        bit rdy, h;
        logic [15:0] t;
        #1;
        check("busy", busy, mclr > 0);
        check("wr_ready", wr_ready, (mclr == 0) && !flush);
        rdy = (mclr == 0) && !flush;
        if (flush) begin mh = 0; mm = 0; end
        else if (e_rv) begin
            if (e_hit) mh = (mh < 3) ? mh + 1 : 3;
            else       mm = (mm < 3) ? mm + 1 : 3;
        end
        if (lk_valid) begin
            if (wr_valid && rdy && wr_key[4:0] == lk_key[4:0]) begin
                h = (wr_key == lk_key); t = wr_target;
            end else begin
                h = mval[lk_key[4:0]] && (mkey[lk_key[4:0]] == lk_key); t = mtgt[lk_key[4:0]];
            end
            e_hit = h && rdy;
            e_tgt = e_hit ? t : 16'h0;
        end
        e_rv = lk_valid;
        if (flush) begin
            foreach (mval[i]) mval[i] = 0;
            mclr = 32;
        end else if (mclr > 0) mclr--;
        else if (wr_valid) begin
            mval[wr_key[4:0]] = 1; mkey[wr_key[4:0]] = wr_key; mtgt[wr_key[4:0]] = wr_target;
        end
        @(posedge clk); #1;
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_hit", rsp_hit, e_hit);
        check("rsp_target", rsp_target, e_tgt);
`ifdef BRANCH_TARGET_TABLE_STATS_EN
        check("hit_count", hit_count, mh);
        check("miss_count", miss_count, mm);
`endif
    endtask

    task automatic go(input bit f, input bit wv, input logic [8:0] wk, input logic [15:0] wt,
                      input bit lv, input logic [8:0] lk);
        flush = f; wr_valid = wv; wr_key = wk; wr_target = wt; lk_valid = lv; lk_key = lk;
        cyc();
    endtask

    task automatic idle_until_ready();
        for (int i = 0; i < 40 && mclr > 0; i++) go(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_rsp_target", rsp_target, 0);
        rst_n = 1;
        go(0, 1, 9'h01D, 16'd99, 1, 9'h01D);
        idle_until_ready();
        go(0, 1, 9'h01D, 16'd10, 0, 0);
        go(0, 1, 9'h03F, 16'd33, 0, 0);
        go(0, 0, 0, 0, 1, 9'h01D);
        go(0, 0, 0, 0, 1, 9'h03F);
        go(0, 0, 0, 0, 1, 9'h021);
        go(0, 1, 9'h03D, 16'd36, 0, 0);
        go(0, 0, 0, 0, 1, 9'h01D);
        go(0, 0, 0, 0, 1, 9'h03D);
        go(0, 1, 9'h071, 16'd21, 1, 9'h071);
        go(0, 1, 9'h071, 16'd22, 1, 9'h051);
        go(0, 0, 0, 0, 1, 9'h071);
        go(0, 1, 9'h101, 16'd1, 0, 0);
        go(0, 1, 9'h102, 16'd2, 0, 0);
        go(0, 1, 9'h103, 16'd3, 0, 0);
        go(0, 1, 9'h104, 16'd4, 1, 9'h101);
        go(1, 1, 9'h105, 16'd5, 1, 9'h102);
        for (int i = 0; i < 10; i++) go(0, 1, 9'h106, 16'd6, 1, 9'h103);
        go(1, 0, 0, 0, 0, 0);
        idle_until_ready();
        go(0, 0, 0, 0, 1, 9'h101);
        go(0, 0, 0, 0, 1, 9'h102);
        go(0, 0, 0, 0, 1, 9'h103);
        go(0, 0, 0, 0, 1, 9'h104);
        go(0, 0, 0, 0, 1, 9'h105);
        for (int i = 0; i < 500; i++) begin
            logic [8:0] wk, lk;
            wk = 9'($urandom_range(0, 3) * 32 + $urandom_range(0, 7));
            lk = 9'($urandom_range(0, 3) * 32 + $urandom_range(0, 7));
            go($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, wk,
               16'($urandom_range(0, 65535)), $urandom_range(0, 9) < 7, lk);
            if (i == 250) begin
                flush = 0; wr_valid = 0; lk_valid = 0;
                rst_n = 0;
                #1;
                check("midrst_busy", busy, 1);
                check("midrst_wr_ready", wr_ready, 0);
                check("midrst_rsp_valid", rsp_valid, 0);
                model_reset();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1;
                go(0, 1, 9'h005, 16'd7, 1, 9'h005);
                idle_until_ready();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
